// File: rtl/voice_mixer.sv
// Time-multiplexed N-voice mixer with per-voice gain/mute, master volume,
// output saturation, frame checking and a first-order sigma-delta DAC.
module voice_mixer #(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned SAMPLE_W   = 10,
    parameter int unsigned GAIN_W     = 4,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned SHIFT      = 4,
    parameter int unsigned IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         sample_tick_i,
    input  logic                         voice_valid_i,
    input  logic [IDX_W-1:0]             voice_idx_i,
    input  logic [SAMPLE_W-1:0]          voice_wave_i,
    output logic                         voice_ready_o,
    input  logic [NUM_VOICES*GAIN_W-1:0] gain_i,
    input  logic [NUM_VOICES-1:0]        mute_i,
    input  logic [3:0]                   master_vol_i,
    input  logic                         err_clr_i,
    output logic [OUT_W-1:0]             audio_o,
    output logic                         audio_valid_o,
    output logic                         clip_o,
    output logic                         frame_err_o,
    output logic                         dac_o
);

    localparam int unsigned ACC_W  = SAMPLE_W + GAIN_W + 1 + $clog2(NUM_VOICES);
    localparam int unsigned PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam int unsigned MUL_W  = ACC_W + 5;
    localparam int unsigned WIDE_W = ((MUL_W > OUT_W) ? MUL_W : OUT_W) + 1;

    localparam logic signed [WIDE_W-1:0] SAT_MAX = {{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] SAT_MIN = {{(WIDE_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]         OUT_MSB  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0]      WAVE_MSB = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCollect, StScale, StEmit} state_e;

    state_e state_q, state_d;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [NUM_VOICES-1:0]   seen_q, seen_d;
    logic                    pend_q, pend_d;
    logic [OUT_W-1:0]        audio_q, audio_d;
    logic                    clip_q, clip_d;
    logic                    err_q, err_d;
    logic [OUT_W-1:0]        dac_acc_q, dac_acc_d;
    logic                    dac_q, dac_d;

    // Voice lane selection; out-of-range indices simply never hit a lane.
    logic                  idx_hit;
    logic                  idx_dup;
    logic                  sel_mute;
    logic [GAIN_W-1:0]     sel_gain;
    logic [NUM_VOICES-1:0] idx_onehot;

    always_comb begin
        idx_hit    = 1'b0;
        idx_dup    = 1'b0;
        sel_mute   = 1'b0;
        sel_gain   = '0;
        idx_onehot = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_idx_i == IDX_W'(v)) begin
                idx_hit       = 1'b1;
                idx_dup       = seen_q[v];
                sel_mute      = mute_i[v];
                sel_gain      = gain_i[v*GAIN_W +: GAIN_W];
                idx_onehot[v] = 1'b1;
            end
        end
    end

    logic signed [SAMPLE_W-1:0] wave_c;
    logic signed [PROD_W-1:0]   wave_ext;
    logic signed [PROD_W-1:0]   gain_ext;
    logic signed [PROD_W-1:0]   term;

    always_comb begin
        wave_c   = $signed(voice_wave_i ^ WAVE_MSB);
        wave_ext = {{(GAIN_W+1){wave_c[SAMPLE_W-1]}}, wave_c};
        gain_ext = $signed({{(SAMPLE_W+1){1'b0}}, sel_gain});
        term     = sel_mute ? '0 : wave_ext * gain_ext;
    end

    logic signed [WIDE_W-1:0] acc_w;
    logic signed [WIDE_W-1:0] vol_w;
    logic signed [WIDE_W-1:0] mix_w;
    logic signed [WIDE_W-1:0] shr_w;
    logic [OUT_W-1:0]         sat_val;
    logic                     sat_clip;

    always_comb begin
        acc_w = WIDE_W'(acc_q);
        vol_w = $signed({{(WIDE_W-4){1'b0}}, master_vol_i});
        mix_w = acc_w * vol_w;
        shr_w = mix_w >>> SHIFT;
        if (shr_w > SAT_MAX) begin
            sat_val  = SAT_MAX[OUT_W-1:0];
            sat_clip = 1'b1;
        end else if (shr_w < SAT_MIN) begin
            sat_val  = SAT_MIN[OUT_W-1:0];
            sat_clip = 1'b1;
        end else begin
            sat_val  = shr_w[OUT_W-1:0];
            sat_clip = 1'b0;
        end
    end

    logic accept;
    logic err_set;

    assign accept = voice_valid_i && (state_q == StCollect);

    always_comb begin
        acc_d   = acc_q;
        seen_d  = seen_q;
        pend_d  = pend_q;
        audio_d = audio_q;
        clip_d  = clip_q;
        err_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sample_tick_i) begin
                    acc_d  = '0;
                    seen_d = '0;
                end
            end
            StCollect: begin
                // A tick here aborts the frame; any same-cycle sample is dropped.
                if (sample_tick_i) begin
                    acc_d   = '0;
                    seen_d  = '0;
                    err_set = 1'b1;
                end else if (accept) begin
                    if (!idx_hit || idx_dup) begin
                        err_set = 1'b1;
                    end else begin
                        acc_d  = acc_q + ACC_W'(term);
                        seen_d = seen_q | idx_onehot;
                    end
                end
            end
            StScale: begin
                audio_d = sat_val;
                clip_d  = sat_clip;
                if (sample_tick_i) pend_d = 1'b1;
            end
            StEmit: begin
                pend_d = 1'b0;
                if (pend_q || sample_tick_i) begin
                    acc_d  = '0;
                    seen_d = '0;
                end
            end
            default: ;
        endcase
        err_d = err_q;
        if (err_clr_i) err_d = 1'b0;
        if (err_set)   err_d = 1'b1;
    end

    // Free-running sigma-delta: carry-out of the offset-binary accumulation.
    logic [OUT_W:0] dac_sum;

    always_comb begin
        dac_sum   = {1'b0, dac_acc_q} + {1'b0, audio_q ^ OUT_MSB};
        dac_acc_d = dac_sum[OUT_W-1:0];
        dac_d     = dac_sum[OUT_W];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (sample_tick_i) state_d = StCollect;
            StCollect: if (!sample_tick_i && (&seen_d)) state_d = StScale;
            StScale:   state_d = StEmit;
            StEmit:    state_d = (pend_q || sample_tick_i) ? StCollect : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        voice_ready_o = 1'b0;
        audio_valid_o = 1'b0;
        clip_o        = 1'b0;
        unique case (state_q)
            StCollect: voice_ready_o = 1'b1;
            StEmit: begin
                audio_valid_o = 1'b1;
                clip_o        = clip_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q     <= '0;
            seen_q    <= '0;
            pend_q    <= 1'b0;
            audio_q   <= '0;
            clip_q    <= 1'b0;
            err_q     <= 1'b0;
            dac_acc_q <= '0;
            dac_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            seen_q    <= seen_d;
            pend_q    <= pend_d;
            audio_q   <= audio_d;
            clip_q    <= clip_d;
            err_q     <= err_d;
            dac_acc_q <= dac_acc_d;
            dac_q     <= dac_d;
        end
    end

    assign audio_o     = audio_q;
    assign frame_err_o = err_q;
    assign dac_o       = dac_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: default instance plus a SHIFT=2 instance on the
// same stimulus to reach saturation.
module tb_voice_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        vvalid = 1'b0;
    logic [1:0]  vidx = '0;
    logic [9:0]  vwave = '0;
    logic [11:0] gain = '0;
    logic [2:0]  mute = '0;
    logic [3:0]  master = '0;
    logic        err_clr = 1'b0;

    logic        ready, avalid, clip, ferr, dac;
    logic [15:0] audio;
    logic        ready2, avalid2, clip2, ferr2, dac2;
    logic [15:0] audio2;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt    = 0;
    int lat;
    int ones;
    int snap;

    always #5 clk = ~clk;

    always @(posedge clk) if (avalid) vcnt++;

    voice_mixer u_dut (
        .clk_i(clk), .rst_i(rst), .sample_tick_i(tick), .voice_valid_i(vvalid),
        .voice_idx_i(vidx), .voice_wave_i(vwave), .voice_ready_o(ready), .gain_i(gain),
        .mute_i(mute), .master_vol_i(master), .err_clr_i(err_clr), .audio_o(audio),
        .audio_valid_o(avalid), .clip_o(clip), .frame_err_o(ferr), .dac_o(dac)
    );

    voice_mixer #(.SHIFT(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .sample_tick_i(tick), .voice_valid_i(vvalid),
        .voice_idx_i(vidx), .voice_wave_i(vwave), .voice_ready_o(ready2), .gain_i(gain),
        .mute_i(mute), .master_vol_i(master), .err_clr_i(err_clr), .audio_o(audio2),
        .audio_valid_o(avalid2), .clip_o(clip2), .frame_err_o(ferr2), .dac_o(dac2)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic voice(input int idx, input int wave);
        vvalid = 1'b1;
        vidx   = idx[1:0];
        vwave  = wave[9:0];
        cyc();
        vvalid = 1'b0;
    endtask

    task automatic wait_emit(output int n);
        n = 0;
        while (!avalid && n < 10) begin
            cyc();
            n++;
        end
    endtask

    task automatic count_dac(output int c);
        c = 0;
        repeat (3) cyc();
        for (int i = 0; i < 1024; i++) begin
            if (dac) c++;
            cyc();
        end
    endtask

    initial begin
        // Reset state
        repeat (2) cyc();
        chk("rst_ready", 32'(ready), 0);
        chk("rst_valid", 32'(avalid), 0);
        chk("rst_clip", 32'(clip), 0);
        chk("rst_err", 32'(ferr), 0);
        chk("rst_audio", 32'(audio), 0);
        chk("rst_dac", 32'(dac), 0);
        rst = 1'b0;
        cyc();

        // Centred samples mix to zero
        gain = {4'd5, 4'd5, 4'd5}; mute = 3'b000; master = 4'd15;
        tick_cyc();
        chk("ready_after_tick", 32'(ready), 1);
        voice(0, 512); voice(1, 512); voice(2, 512);
        chk("scale_ready", 32'(ready), 0);
        chk("scale_valid", 32'(avalid), 0);
        wait_emit(lat);
        chk("zero_latency", 32'(lat), 1);
        chk("zero_audio", 32'(audio), 0);
        chk("zero_clip", 32'(clip), 0);
        cyc();
        chk("valid_one_cycle", 32'(avalid), 0);
        snap = vcnt;
        count_dac(ones);
        chk("dac_zero_ones", 32'(ones), 512);
        chk("no_stray_valid", 32'(vcnt), 32'(snap));

        // Single voice, others muted
        gain = {4'd15, 4'd15, 4'd15}; mute = 3'b110;
        tick_cyc();
        voice(0, 1023); voice(1, 1023); voice(2, 1023);
        wait_emit(lat);
        chk("single_lat", 32'(lat), 1);
        chk("single_audio", 32'(audio), 7185);
        chk("single_clip", 32'(clip), 0);
        cyc();

        // Full-scale negative: fits at SHIFT=4, saturates at SHIFT=2
        mute = 3'b000;
        tick_cyc();
        voice(0, 0); voice(1, 0); voice(2, 0);
        wait_emit(lat);
        chk("neg_lat", 32'(lat), 1);
        chk("neg_audio", 32'(audio), 32'h0000_ABA0);
        chk("neg_clip", 32'(clip), 0);
        chk("sat_valid", 32'(avalid2), 1);
        chk("sat_audio", 32'(audio2), 32'h0000_8000);
        chk("sat_clip", 32'(clip2), 1);
        cyc();
        chk("clip_low_after", 32'(clip2), 0);

        // Abort by tick mid-collect, with a same-cycle handshake dropped
        snap = vcnt;
        tick_cyc();
        voice(0, 1023);
        tick = 1'b1;
        voice(0, 0);
        tick = 1'b0;
        chk("abort_err", 32'(ferr), 1);
        chk("abort_ready", 32'(ready), 1);
        voice(0, 1023); voice(1, 1023); voice(2, 1023);
        wait_emit(lat);
        chk("abort_lat", 32'(lat), 1);
        chk("abort_audio", 32'(audio), 21557);
        cyc();
        chk("abort_pulses", 32'(vcnt - snap), 1);
        chk("abort_err_sticky", 32'(ferr), 1);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        chk("err_cleared", 32'(ferr), 0);

        // Duplicate index is ignored
        mute = 3'b110;
        tick_cyc();
        voice(0, 1023); voice(0, 0); voice(1, 512); voice(2, 512);
        wait_emit(lat);
        chk("dup_audio", 32'(audio), 7185);
        chk("dup_err", 32'(ferr), 1);
        cyc();
        err_clr = 1'b1; cyc(); err_clr = 1'b0;

        // Out-of-range index is ignored
        mute = 3'b000;
        tick_cyc();
        voice(3, 0);
        chk("badidx_err", 32'(ferr), 1);
        voice(0, 512); voice(1, 512); voice(2, 512);
        wait_emit(lat);
        chk("badidx_audio", 32'(audio), 0);
        cyc();
        err_clr = 1'b1; cyc(); err_clr = 1'b0;

        // Three-quarter duty DAC: 7665 + 7665 + 485*7 = 18725, *14 >>> 4 = 16384
        gain = {4'd7, 4'd15, 4'd15}; master = 4'd14;
        tick_cyc();
        voice(0, 1023); voice(1, 1023); voice(2, 997);
        wait_emit(lat);
        chk("dac_frame_audio", 32'(audio), 32'h0000_4000);
        count_dac(ones);
        chk("dac_half_ones", 32'(ones), 768);

        // Tick during SCALE is held and starts the next frame directly
        gain = {4'd15, 4'd15, 4'd15}; master = 4'd15;
        tick_cyc();
        voice(0, 1023); voice(1, 1023);
        vvalid = 1'b1; vidx = 2'd2; vwave = 10'd1023;
        cyc();
        vvalid = 1'b0;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("pend_valid", 32'(avalid), 1);
        chk("pend_audio", 32'(audio), 21557);
        cyc();
        chk("pend_ready", 32'(ready), 1);
        voice(0, 512); voice(1, 512); voice(2, 512);
        wait_emit(lat);
        chk("pend_lat", 32'(lat), 1);
        chk("pend_audio2", 32'(audio), 0);
        chk("pend_err", 32'(ferr), 0);
        cyc();

        // Reset mid-frame discards the frame
        tick_cyc();
        voice(0, 1023);
        rst = 1'b1; cyc(); rst = 1'b0;
        snap = vcnt;
        repeat (6) cyc();
        chk("midrst_pulses", 32'(vcnt - snap), 0);
        chk("midrst_ready", 32'(ready), 0);
        chk("midrst_audio", 32'(audio), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Parametrised time-multiplexed voice mixer sitting between the envelope stage and the chip outputs of the SID-like synth. It collects one envelope-shaped sample per voice per sample frame and applies per-voice gain and mute plus master volume. It saturates the sum to a signed output word and drives a first-order sigma-delta 1-bit DAC stream. It generalises the fixed 3-voice, bit-sliced audio path to N voices with gain control, frame checking and a pin-level DAC.

## Interface
- NUM_VOICES, 3, voices per frame (≥1)
- SAMPLE_W, 10, unsigned offset-binary voice sample width
- GAIN_W, 4, unsigned per-voice gain width
- OUT_W, 16, signed output width
- SHIFT, 4, arithmetic right shift applied after master volume
- IDX_W is derived as max(1, $clog2(NUM_VOICES)).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- sample_tick_i  in  1  frame start pulse
- voice_valid_i  in  1  sample offered
- voice_idx_i  in  IDX_W  voice index of offered sample
- voice_wave_i  in  SAMPLE_W  offset-binary sample
- voice_ready_o  out  1  mixer accepts samples
- gain_i  in  NUM_VOICES*GAIN_W  per-voice gain, voice v at [v*GAIN_W +: GAIN_W]
- mute_i  in  NUM_VOICES  per-voice mute
- master_vol_i  in  4  master volume 0..15
- err_clr_i  in  1  clears frame_err_o
- audio_o  out  OUT_W  signed mixed sample
- audio_valid_o  out  1  one-cycle pulse, new audio_o
- clip_o  out  1  saturation flag, valid with audio_valid_o
- frame_err_o  out  1  sticky frame error
- dac_o  out  1  sigma-delta bitstream

## Operation
- FSM states: IDLE, COLLECT, SCALE, EMIT.
- IDLE: on sample_tick_i, clear the accumulator and the seen-mask, then go to COLLECT.
- COLLECT: voice_ready_o=1. Accept on valid&ready:
  - Centre the sample: s = wave − 2^(SAMPLE_W−1), signed.
  - Compute the term: p = mute[idx] ? 0 : s·gain[idx].
  - Add p to the accumulator and set seen[idx].
  - gain_i and mute_i are sampled at acceptance.
- Accumulator width is SAMPLE_W+GAIN_W+1+$clog2(NUM_VOICES); it can never overflow.
- An idx ≥ NUM_VOICES is consumed and ignored, and sets frame_err_o.
- A duplicate idx already in seen is consumed and ignored, and sets frame_err_o.
- When seen is all-ones, go to SCALE.
- SCALE:
  - Compute m = acc·master_vol_i, with master_vol_i sampled in this cycle.
  - Compute r = m >>> SHIFT.
  - Saturate r to [−2^(OUT_W−1), 2^(OUT_W−1)−1], register it into audio_o, and set clip_o if saturated.
  - Go to EMIT.
- EMIT: audio_valid_o=1 for one cycle. Go to COLLECT (cleared) if a tick is pending, else to IDLE.
- Tick handling:
  - Tick in COLLECT: abort the frame, set frame_err_o, clear the accumulator and seen, and stay in COLLECT. No audio_valid_o is produced for the aborted frame. A handshake in the same cycle is consumed and discarded.
  - Tick in SCALE or EMIT: the current frame completes; set the pending flag.
- frame_err_o clears only on err_clr_i. If err_clr_i and a new error occur in the same cycle, the error wins (flag stays 1).
- DAC:
  - Each cycle, d = d + (audio_o ^ 2^(OUT_W−1)), where d is OUT_W bits unsigned.
  - dac_o is registered as the carry-out.
  - This runs continuously, independent of the FSM.

## Timing
- Reset (asynchronous, rst_i=1):
  - State is IDLE; accumulator, seen, pending and d are 0.
  - audio_o, audio_valid_o, clip_o, voice_ready_o, frame_err_o and dac_o are all 0.
- Tick at cycle T → voice_ready_o=1 from T+1.
- Last voice accepted at cycle A:
  - SCALE in A+1, voice_ready_o=0.
  - audio_o updates at the end of A+1.
  - audio_valid_o and clip_o are high in A+2.
- audio_o holds its value until the next SCALE.
- clip_o is meaningful only while audio_valid_o=1, and is 0 otherwise.
- Reset asserted mid-frame discards the frame immediately. No audio_valid_o pulse follows until a new tick arrives.
- Back-to-back ticks at minimum spacing of NUM_VOICES+3 cycles produce one frame per tick with no error.

## Test plan
Defaults apply unless stated.
- All voices wave=512, any gain, master 15 → audio_o=0, clip_o=0, audio_valid_o in A+2.
- Voice0 wave=1023, gain 15; voices 1–2 muted; master 15 → audio_o=7185, clip_o=0.
- SHIFT=2; all voices wave=0, gain 15, master 15 → r=−86400, audio_o=−32768 (0x8000), clip_o=1.
- Tick after one accepted voice, then a full frame of wave=1023, gain 15, master 15 → frame_err_o=1, exactly one audio_valid_o pulse, audio_o=21557. err_clr_i then → frame_err_o=0.
- Duplicate idx 0 within a frame (wave 1023, then wave 0) → second sample ignored, frame_err_o=1, result identical to the single-sample case.
- audio_o held at 0 for 1024 cycles → 512 ones on dac_o. audio_o=16384 → 768 ones in 1024 cycles.
